muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide execution unit sitting directly downstream of the register file.
- Consumes ReadData1/ReadData2 as operands and returns a 32-bit result plus destination register index, to be written back through WriteData/WriteRegister/WriteSignal.
- Implements the eight RV32M operations with a fixed-latency shift-add multiplier and restoring divider.
- The CPU stalls on busy.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- flush  input  1  synchronous abort of an in-flight operation.
- op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- operand_a  input  WIDTH  rs1 value (from ReadData1).
- operand_b  input  WIDTH  rs2 value (from ReadData2).
- dest_reg  input  REG_ADDR_W  rd index.
- busy  output  1  high from the cycle after start acceptance until done is low again.
- done  output  1  one-cycle pulse; drives WriteSignal.
- result  output  WIDTH  final value; drives WriteData.
- result_reg  output  REG_ADDR_W  captured rd; drives WriteRegister.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, result=0, result_reg=0; all internal registers cleared. Reset mid-operation abandons the operation; no done is produced.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
  - IDLE: on start=1 at edge k, capture op, dest_reg and |a|, |b| (sign per op), plus result-sign flags. Go to CALC; counter=WIDTH-1.
  - CALC: one iteration per cycle for exactly WIDTH cycles (edges k+1..k+WIDTH).
    - Multiply: 2*WIDTH accumulator, shift-add on LSB of multiplier.
    - Divide: restoring shift-subtract, one quotient bit per cycle.
  - FIX: apply sign correction and select the low/high half or quotient/remainder. Register into result.
  - DONE: done=1 for exactly one cycle; result and result_reg valid. Next edge returns to IDLE.
- Latency: done is high in the cycle following edge k+WIDTH+2, i.e. 34 cycles after the start edge for WIDTH=32. Latency is fixed for all ops and operands; there is no early exit.
- result and result_reg hold their value after done until the next accepted start.
- start while not IDLE is ignored; operands are not re-sampled.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - MUL: low WIDTH bits, identical for any signedness.
- Divide by zero: quotient = all ones (DIV and DIVU); remainder = operand_a unmodified (REM and REMU).
- Signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV returns 0x80000000, REM returns 0.
- Remainder sign follows the dividend; quotient truncates toward zero.
- flush=1 in any state: next state IDLE, busy=0, done not asserted (flush during DONE suppresses nothing already pulsed). Flush has priority over start in the same cycle.
- dest_reg=0 is passed through unchanged; the register file discards writes to r0.

Decomposition:
- Shared package cpu_pkg:
  - funct3 localparams OP_MUL..OP_REMU.
  - State encoding MD_IDLE/MD_CALC/MD_FIX/MD_DONE.
  - Constants XLEN=32 and REG_ADDR_W=5.
- One natural sub-module: muldiv_core, the per-cycle datapath (accumulator/remainder shift and add/subtract step).
- The FSM, sign handling and output registers stay in muldiv_unit.

Test Plan:
- MUL a=7, b=0xFFFFFFFD -> result=0xFFFFFFEB, result_reg=captured rd. done pulses exactly once, 34 cycles after start; busy high in between.
- MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF. REMU 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM same operands -> 0.
- Second start pulsed at cycle 10 of an operation is ignored: only one done pulse, and the result matches the first operands. Changing operand_a mid-operation does not alter the result.
- Async rst asserted at cycle 15 -> outputs zero immediately, with no done. flush at cycle 20 -> busy=0 next cycle, no done. A new start afterwards completes normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: RV32M funct3 codes, multiply/divide FSM states, core widths.
package cpu_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_CALC,
        MD_FIX,
        MD_DONE
    } md_state_t;

endpackage

// File: rtl/muldiv_core.sv
// One iteration of the unsigned shift-add multiplier or restoring divider.
// acc holds {hi, lo}: product high half / multiplier, or partial remainder / dividend-quotient.
module muldiv_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc_step_c
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] trial;

    always_comb begin
        acc_step_c = acc;
        sum        = '0;
        trial      = '0;
        if (is_div) begin
            // Shift in the next dividend bit and try to subtract; a borrow restores.
            trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
            if (!trial[WIDTH]) begin
                acc_step_c = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_step_c = {acc[2*WIDTH-2:0], 1'b0};
            end
        end else begin
            sum        = {1'b0, acc[2*WIDTH-1:WIDTH]}
                       + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
            acc_step_c = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Fixed-latency RV32M multiply/divide unit: sign handling, iteration FSM and
// registered write-back outputs around the muldiv_core datapath step.
module muldiv_unit #(
    parameter int unsigned WIDTH      = cpu_pkg::XLEN,
    parameter int unsigned REG_ADDR_W = cpu_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  flush,
    input  logic [2:0]            op,
    input  logic [WIDTH-1:0]      operand_a,
    input  logic [WIDTH-1:0]      operand_b,
    input  logic [REG_ADDR_W-1:0] dest_reg,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      result,
    output logic [REG_ADDR_W-1:0] result_reg
);
    import cpu_pkg::*;

    localparam int unsigned CNT_W = $clog2(WIDTH);

    md_state_t             state;
    logic [2:0]            op_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [2*WIDTH-1:0]    acc;
    logic [2*WIDTH-1:0]    acc_step_c;
    logic [WIDTH-1:0]      operand_q;
    logic [CNT_W-1:0]      count;
    logic                  is_div;
    logic                  neg_lo;
    logic                  neg_rem;
    logic                  div_zero;

    logic                  sign_a_c, sign_b_c, neg_a_c, neg_b_c;
    logic [WIDTH-1:0]      mag_a_c, mag_b_c;
    logic [2*WIDTH-1:0]    prod_c;
    logic [WIDTH-1:0]      quot_c, rem_c, fixed_c;

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .is_div     (is_div),
        .acc        (acc),
        .operand    (operand_q),
        .acc_step_c (acc_step_c)
    );

    // Operand magnitudes; the datapath only ever sees unsigned values.
    always_comb begin
        sign_a_c = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        sign_b_c = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        neg_a_c  = sign_a_c & operand_a[WIDTH-1];
        neg_b_c  = sign_b_c & operand_b[WIDTH-1];
        mag_a_c  = neg_a_c ? -operand_a : operand_a;
        mag_b_c  = neg_b_c ? -operand_b : operand_b;
    end

    // Sign correction and half/quotient/remainder selection.
    always_comb begin
        prod_c = neg_lo ? -acc : acc;
        quot_c = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_c  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        case (op_q)
            OP_MUL:                       fixed_c = prod_c[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fixed_c = prod_c[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              fixed_c = div_zero ? '1 : quot_c;
            default:                      fixed_c = rem_c;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= MD_IDLE;
            op_q       <= '0;
            rd_q       <= '0;
            acc        <= '0;
            operand_q  <= '0;
            count      <= '0;
            is_div     <= 1'b0;
            neg_lo     <= 1'b0;
            neg_rem    <= 1'b0;
            div_zero   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            result_reg <= '0;
        end else if (flush) begin
            state <= MD_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        op_q      <= op;
                        rd_q      <= dest_reg;
                        acc       <= {{WIDTH{1'b0}}, mag_a_c};
                        operand_q <= mag_b_c;
                        is_div    <= op[2];
                        neg_lo    <= neg_a_c ^ neg_b_c;
                        neg_rem   <= neg_a_c;
                        div_zero  <= (operand_b == '0);
                        count     <= CNT_W'(WIDTH - 1);
                        busy      <= 1'b1;
                        state     <= MD_CALC;
                    end
                end
                MD_CALC: begin
                    acc   <= acc_step_c;
                    count <= count - CNT_W'(1);
                    if (count == '0) begin
                        state <= MD_FIX;
                    end
                end
                MD_FIX: begin
                    result     <= fixed_c;
                    result_reg <= rd_q;
                    state      <= MD_DONE;
                end
                MD_DONE: begin
                    // First DONE cycle raises the pulse; the second retires it.
                    if (!done) begin
                        done <= 1'b1;
                    end else begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= MD_IDLE;
                    end
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: latency, RV32M results, edge cases, abort paths.
module tb_muldiv_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [2:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  dest_reg;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  result_reg;

    int total = 0;
    int bad   = 0;

    muldiv_unit dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .flush      (flush),
        .op         (op),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .dest_reg   (dest_reg),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .result_reg (result_reg)
    );

    always #5 clk = ~clk;

    // Issue one operation and watch 40 cycles: first done latency, pulse count, captured outputs.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rres,
                         output int lat, output int pulses);
        @(negedge clk);
        op = o; operand_a = a; operand_b = b; dest_reg = rd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1; pulses = 0; res = '0; rres = '0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
                pulses++;
                if (lat < 0) begin
                    lat = i; res = result; rres = result_reg;
                end
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0;
        operand_a = '0; operand_b = '0; dest_reg = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({busy, done} !== 2'b00) begin
            bad++; $display("FAIL reset_flags got busy=%b done=%b want 0 0", busy, done);
        end
        total++;
        if (result !== 32'h0 || result_reg !== 5'h0) begin
            bad++; $display("FAIL reset_outputs got result=%h reg=%h want 0 0", result, result_reg);
        end
    endtask

    task automatic test_mul_timing;
        int first_done = -1;
        int pulses = 0;
        bit busy_ok = 1'b1;
        logic [31:0] res = '0;
        logic [4:0] rres = '0;
        @(negedge clk);
        op = OP_MUL; operand_a = 32'd7; operand_b = 32'hFFFFFFFD; dest_reg = 5'd12; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (busy !== (i <= 34)) busy_ok = 1'b0;
            if (done) begin
                pulses++;
                if (first_done < 0) begin
                    first_done = i; res = result; rres = result_reg;
                end
            end
        end
        total++;
        if (first_done != 34) begin
            bad++; $display("FAIL mul_latency got %0d want 34", first_done);
        end
        total++;
        if (pulses != 1) begin
            bad++; $display("FAIL mul_pulses got %0d want 1", pulses);
        end
        total++;
        if (!busy_ok) begin
            bad++; $display("FAIL mul_busy_window got mismatched busy want high cycles 1..34 only");
        end
        total++;
        if (res !== 32'hFFFFFFEB) begin
            bad++; $display("FAIL mul_result got %h want ffffffeb", res);
        end
        total++;
        if (rres !== 5'd12) begin
            bad++; $display("FAIL mul_rd got %0d want 12", rres);
        end
        total++;
        if (result !== 32'hFFFFFFEB) begin
            bad++; $display("FAIL mul_hold got %h want ffffffeb", result);
        end
    endtask

    task automatic test_mul_high;
        logic [2:0]  ops  [3] = '{OP_MULHU, OP_MULH, OP_MULHSU};
        logic [31:0] va   [3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] vb   [3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000002};
        logic [31:0] want [3] = '{32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF};
        logic [31:0] res;
        logic [4:0]  rres;
        int lat, pulses;
        for (int i = 0; i < 3; i++) begin
            do_op(ops[i], va[i], vb[i], 5'(i + 1), res, rres, lat, pulses);
            total++;
            if (res !== want[i] || lat != 34) begin
                bad++; $display("FAIL mulh_case%0d got %h lat=%0d want %h lat=34", i, res, lat, want[i]);
            end
        end
    endtask

    task automatic test_divide;
        logic [2:0]  ops  [8] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIVU, OP_REMU, OP_DIV, OP_REM};
        logic [31:0] va   [8] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100,
                                  32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] vb   [8] = '{32'd2, 32'd2, 32'd7, 32'd7,
                                  32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] want [8] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2,
                                  32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
        logic [31:0] res;
        logic [4:0]  rres;
        int lat, pulses;
        for (int i = 0; i < 8; i++) begin
            do_op(ops[i], va[i], vb[i], 5'(i), res, rres, lat, pulses);
            total++;
            if (res !== want[i] || rres !== 5'(i) || lat != 34 || pulses != 1) begin
                bad++;
                $display("FAIL div_case%0d got %h rd=%0d lat=%0d pulses=%0d want %h rd=%0d lat=34 pulses=1",
                         i, res, rres, lat, pulses, want[i], i);
            end
        end
    endtask

    task automatic test_ignore_start;
        int first_done = -1;
        int pulses = 0;
        logic [31:0] res = '0;
        logic [4:0] rres = '0;
        @(negedge clk);
        op = OP_DIVU; operand_a = 32'd100; operand_b = 32'd7; dest_reg = 5'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (i == 10) start = 1'b0;
            if (done) begin
                pulses++;
                if (first_done < 0) begin
                    first_done = i; res = result; rres = result_reg;
                end
            end
            if (i == 9) begin
                @(negedge clk);
                start = 1'b1; op = OP_MUL; operand_a = 32'd1000; operand_b = 32'd3; dest_reg = 5'd7;
            end
        end
        total++;
        if (pulses != 1 || first_done != 34) begin
            bad++; $display("FAIL ignore_start_pulse got pulses=%0d lat=%0d want 1 34", pulses, first_done);
        end
        total++;
        if (res !== 32'd14 || rres !== 5'd4) begin
            bad++; $display("FAIL ignore_start_result got %h rd=%0d want 0000000e rd=4", res, rres);
        end
    endtask

    task automatic test_async_reset;
        int pulses = 0;
        @(negedge clk);
        op = OP_MUL; operand_a = 32'd7; operand_b = 32'd9; dest_reg = 5'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({busy, done} !== 2'b00 || result !== 32'h0 || result_reg !== 5'h0) begin
            bad++;
            $display("FAIL async_reset got busy=%b done=%b result=%h reg=%h want all zero",
                     busy, done, result, result_reg);
        end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++; $display("FAIL async_reset_no_done got %0d pulses want 0", pulses);
        end
    endtask

    task automatic test_flush;
        int pulses = 0;
        logic [31:0] res;
        logic [4:0]  rres;
        int lat, p2;
        @(negedge clk);
        op = OP_DIVU; operand_a = 32'd100; operand_b = 32'd7; dest_reg = 5'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL flush_busy got busy=%b done=%b want 0 0", busy, done);
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++; $display("FAIL flush_no_done got %0d pulses want 0", pulses);
        end
        do_op(OP_REMU, 32'd100, 32'd7, 5'd11, res, rres, lat, p2);
        total++;
        if (res !== 32'd2 || rres !== 5'd11 || lat != 34 || p2 != 1) begin
            bad++;
            $display("FAIL after_flush got %h rd=%0d lat=%0d pulses=%0d want 00000002 rd=11 lat=34 pulses=1",
                     res, rres, lat, p2);
        end
    endtask

    initial begin
        test_reset();
        test_mul_timing();
        test_mul_high();
        test_divide();
        test_ignore_start();
        test_async_reset();
        test_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
